// File: rtl/regfile_arb.sv
// Two-requester (core/debug) register-file port arbiter with lock ownership and registered response.
// Optional write-to-read bypass on the response path when RF_ARB_BYPASS_EN is defined.
module regfile_arb #(
   parameter int AW = 6,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [1:0]      req_lock,
   input  logic [1:0]      req_we,
   input  logic [2*AW-1:0] req_ra1,
   input  logic [2*AW-1:0] req_ra2,
   input  logic [2*AW-1:0] req_wa,
   input  logic [2*DW-1:0] req_wd,
   output logic            rf_we1,
   output logic [AW-1:0]   rf_ra1,
   output logic [AW-1:0]   rf_ra2,
   output logic [AW-1:0]   rf_wa,
   output logic [DW-1:0]   rf_wd,
   input  logic [DW-1:0]   rf_rd1,
   input  logic [DW-1:0]   rf_rd2,
   output logic [1:0]      rsp_valid,
   output logic [DW-1:0]   rsp_rd1,
   output logic [DW-1:0]   rsp_rd2
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t     state, state_nxt;
   logic       rr, rr_nxt;
   logic [1:0] xfer;
   logic       sel;
   logic       winner;

   assign xfer   = req_valid & req_ready;
   assign winner = xfer[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rr    <= 1'b0;
      end else begin
         state <= state_nxt;
         rr    <= rr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr;
      case (state)
         IDLE: begin
            if (xfer != 2'b00) begin
               rr_nxt = ~winner;
               if (req_lock[winner]) state_nxt = winner ? OWN1 : OWN0;
            end
         end
         OWN0: begin
            if (!req_lock[0]) begin
               state_nxt = IDLE;
               rr_nxt    = 1'b1;
            end
         end
         OWN1: begin
            if (!req_lock[1]) begin
               state_nxt = IDLE;
               rr_nxt    = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant is combinational; gated by rst_n so nothing is offered while reset is held.
   always_comb begin
      req_ready = '0;
      case (state)
         IDLE:    if (req_valid == 2'b11) req_ready[rr] = 1'b1;
                  else                    req_ready = req_valid;
         OWN0:    req_ready[0] = req_valid[0];
         OWN1:    req_ready[1] = req_valid[1];
         default: req_ready = '0;
      endcase
      if (!rst_n) req_ready = '0;

      sel    = req_ready[1];
      rf_we1 = 1'b0;
      rf_ra1 = '0;
      rf_ra2 = '0;
      rf_wa  = '0;
      rf_wd  = '0;
      if (req_ready != 2'b00) begin
         rf_we1 = req_we[sel];
         rf_ra1 = sel ? req_ra1[2*AW-1:AW] : req_ra1[AW-1:0];
         rf_ra2 = sel ? req_ra2[2*AW-1:AW] : req_ra2[AW-1:0];
         rf_wa  = sel ? req_wa[2*AW-1:AW]  : req_wa[AW-1:0];
         rf_wd  = sel ? req_wd[2*DW-1:DW]  : req_wd[DW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rsp_valid <= '0;
      else        rsp_valid <= xfer;
   end

`ifdef RF_ARB_BYPASS_EN
   logic          byp1, byp2;
   logic [DW-1:0] byp_wd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp1   <= 1'b0;
         byp2   <= 1'b0;
         byp_wd <= '0;
      end else begin
         byp1   <= rf_we1 && (rf_ra1 == rf_wa);
         byp2   <= rf_we1 && (rf_ra2 == rf_wa);
         byp_wd <= rf_wd;
      end
   end

   always_comb begin
      rsp_rd1 = '0;
      rsp_rd2 = '0;
      if (rsp_valid != 2'b00) begin
         rsp_rd1 = byp1 ? byp_wd : rf_rd1;
         rsp_rd2 = byp2 ? byp_wd : rf_rd2;
      end
   end
`else
   always_comb begin
      rsp_rd1 = '0;
      rsp_rd2 = '0;
      if (rsp_valid != 2'b00) begin
         rsp_rd1 = rf_rd1;
         rsp_rd2 = rf_rd2;
      end
   end
`endif

endmodule

// File: tb/tb_regfile_arb.sv
// Bench for regfile_arb: behavioural register file, per-scenario tasks, response scoreboard.
module tb_regfile_arb;
   localparam int AW = 6;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_valid, req_ready, req_lock, req_we, rsp_valid;
   logic [2*AW-1:0] req_ra1, req_ra2, req_wa;
   logic [2*DW-1:0] req_wd;
   logic            rf_we1;
   logic [AW-1:0]   rf_ra1, rf_ra2, rf_wa;
   logic [DW-1:0]   rf_wd, rf_rd1, rf_rd2, rsp_rd1, rsp_rd2;

   typedef struct packed {
      logic [1:0]    vld;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
   } rsp_t;

   rsp_t          sb[$];
   logic [DW-1:0] shadow [2**AW];
   logic [DW-1:0] rf_mem [2**AW];
   logic          mem_clr;
   int            nchk = 0;
   int            nerr = 0;

   always #5 clk = ~clk;

   regfile_arb #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock), .req_we(req_we),
      .req_ra1(req_ra1), .req_ra2(req_ra2), .req_wa(req_wa), .req_wd(req_wd),
      .rf_we1(rf_we1), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .rsp_valid(rsp_valid), .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2)
   );

   // Register file: one-cycle read latency, read-before-write.
   always @(posedge clk) begin
      rf_rd1 <= rf_mem[rf_ra1];
      rf_rd2 <= rf_mem[rf_ra2];
      if (mem_clr) begin
         for (int k = 0; k < 2**AW; k++) rf_mem[k] <= '0;
      end else if (rf_we1) begin
         rf_mem[rf_wa] <= rf_wd;
      end
   end

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
      req_we[i]             = we;
      req_wa[i*AW +: AW]    = wa;
      req_wd[i*DW +: DW]    = wd;
      req_ra1[i*AW +: AW]   = ra1;
      req_ra2[i*AW +: AW]   = ra2;
   endtask

   // Expected response for the requester the scenario says is granted this cycle.
   task automatic push_expected(input logic [1:0] g);
      rsp_t          e;
      int            i;
      logic [AW-1:0] a1, a2, wa;
      logic [DW-1:0] wd;
      logic          we;
      e     = '0;
      e.vld = g;
      if (g != 2'b00) begin
         i  = g[1] ? 1 : 0;
         a1 = req_ra1[i*AW +: AW];
         a2 = req_ra2[i*AW +: AW];
         wa = req_wa[i*AW +: AW];
         wd = req_wd[i*DW +: DW];
         we = req_we[i];
         e.rd1 = shadow[a1];
         e.rd2 = shadow[a2];
`ifdef RF_ARB_BYPASS_EN
         if (we && a1 == wa) e.rd1 = wd;
         if (we && a2 == wa) e.rd2 = wd;
`endif
         if (we) shadow[wa] = wd;
      end
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      req_lock  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic test_reset();
      rsp_t e;
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_lock  = 2'b00;
      set_req(0, 1'b1, AW'(7), 32'h1111_1111, AW'(1), AW'(7));
      set_req(1, 1'b0, '0, '0, AW'(3), AW'(4));
      sb.delete();
      repeat (2) @(negedge clk);
      #1;
      nchk++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL reset ready: got %b want 00", req_ready); end
      nchk++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL reset rsp_valid: got %b want 00", rsp_valid); end
      nchk++; if (rf_we1 !== 1'b0) begin nerr++; $display("FAIL reset rf_we1: got %b want 0", rf_we1); end
      nchk++; if (rsp_rd1 !== '0 || rsp_rd2 !== '0) begin nerr++; $display("FAIL reset rsp_rd: got %h/%h want 0/0", rsp_rd1, rsp_rd2); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL reset first grant: got %b want 01", req_ready); end
      nchk++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL reset rsp after release: got %b want 00", rsp_valid); end
      push_expected(2'b01);
      @(negedge clk);
      e = sb.pop_front();
      nchk++; if (rsp_valid !== e.vld) begin nerr++; $display("FAIL reset rsp_valid: got %b want %b", rsp_valid, e.vld); end
      nchk++; if (rsp_rd1 !== e.rd1) begin nerr++; $display("FAIL reset rsp_rd1: got %h want %h", rsp_rd1, e.rd1); end
      nchk++; if (rsp_rd2 !== e.rd2) begin nerr++; $display("FAIL reset rsp_rd2: got %h want %h", rsp_rd2, e.rd2); end
      req_valid = '0;
      push_expected(2'b00);
   endtask

   task automatic test_contention();
      rsp_t          e;
      logic [1:0]    g;
      logic [AW-1:0] xa;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         e = '0;
         if (sb.size() != 0) e = sb.pop_front();
         nchk++; if (rsp_valid !== e.vld) begin nerr++; $display("FAIL contention rsp_valid %0d: got %b want %b", c, rsp_valid, e.vld); end
         nchk++; if (rsp_rd1 !== e.rd1) begin nerr++; $display("FAIL contention rsp_rd1 %0d: got %h want %h", c, rsp_rd1, e.rd1); end
         nchk++; if (rsp_rd2 !== e.rd2) begin nerr++; $display("FAIL contention rsp_rd2 %0d: got %h want %h", c, rsp_rd2, e.rd2); end
         if (c < 4) begin
            req_valid = 2'b11;
            req_lock  = 2'b00;
            set_req(0, 1'b1, AW'(20+c), 32'hA000_0000 + c, AW'(20+c), AW'(21));
            set_req(1, 1'b0, '0, '0, AW'(19+c), AW'(20+c));
            g  = (c % 2 == 1) ? 2'b10 : 2'b01;
            xa = (c % 2 == 1) ? AW'(19+c) : AW'(20+c);
            #1;
            nchk++; if (req_ready !== g) begin nerr++; $display("FAIL contention ready %0d: got %b want %b", c, req_ready, g); end
            nchk++; if (rf_we1 !== g[0]) begin nerr++; $display("FAIL contention rf_we1 %0d: got %b want %b", c, rf_we1, g[0]); end
            nchk++; if (rf_ra1 !== xa) begin nerr++; $display("FAIL contention rf_ra1 %0d: got %0d want %0d", c, rf_ra1, xa); end
            push_expected(g);
         end else begin
            req_valid = '0;
            push_expected(2'b00);
         end
      end
   endtask

   task automatic test_lock();
      rsp_t       e;
      logic [1:0] vt [7] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
      logic [1:0] lt [7] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
      logic [1:0] gt [7] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
      for (int s = 0; s < 7; s++) begin
         @(negedge clk);
         e = '0;
         if (sb.size() != 0) e = sb.pop_front();
         nchk++; if (rsp_valid !== e.vld) begin nerr++; $display("FAIL lock rsp_valid %0d: got %b want %b", s, rsp_valid, e.vld); end
         nchk++; if (rsp_rd1 !== e.rd1) begin nerr++; $display("FAIL lock rsp_rd1 %0d: got %h want %h", s, rsp_rd1, e.rd1); end
         nchk++; if (rsp_rd2 !== e.rd2) begin nerr++; $display("FAIL lock rsp_rd2 %0d: got %h want %h", s, rsp_rd2, e.rd2); end
         req_valid = vt[s];
         req_lock  = lt[s];
         set_req(0, 1'b0, '0, '0, AW'(39+s), AW'(40+s));
         set_req(1, 1'b1, AW'(40+s), 32'hB000_0000 + s, AW'(40+s), AW'(41));
         #1;
         nchk++; if (req_ready !== gt[s]) begin nerr++; $display("FAIL lock ready %0d: got %b want %b", s, req_ready, gt[s]); end
         push_expected(gt[s]);
      end
   endtask

   task automatic test_bypass();
      rsp_t e;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         e = '0;
         if (sb.size() != 0) e = sb.pop_front();
         nchk++; if (rsp_valid !== e.vld) begin nerr++; $display("FAIL bypass rsp_valid %0d: got %b want %b", s, rsp_valid, e.vld); end
         nchk++; if (rsp_rd1 !== e.rd1) begin nerr++; $display("FAIL bypass rsp_rd1 %0d: got %h want %h", s, rsp_rd1, e.rd1); end
         nchk++; if (rsp_rd2 !== e.rd2) begin nerr++; $display("FAIL bypass rsp_rd2 %0d: got %h want %h", s, rsp_rd2, e.rd2); end
         if (s == 1) begin
`ifdef RF_ARB_BYPASS_EN
            nchk++; if (rsp_rd1 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL bypass same-addr rd1: got %h want deadbeef", rsp_rd1); end
`else
            nchk++; if (rsp_rd1 !== 32'h0) begin nerr++; $display("FAIL bypass same-addr rd1: got %h want 0", rsp_rd1); end
`endif
         end
         req_lock  = '0;
         req_valid = (s < 2) ? 2'b01 : 2'b00;
         set_req(0, s == 0, AW'(5), 32'hDEAD_BEEF, AW'(5), AW'(5+s));
         set_req(1, 1'b0, '0, '0, '0, '0);
         #1;
         if (s == 0) begin
            nchk++; if (rf_we1 !== 1'b1 || rf_wa !== AW'(5) || rf_wd !== 32'hDEAD_BEEF) begin
               nerr++; $display("FAIL bypass rf write: got we=%b wa=%0d wd=%h want 1/5/deadbeef", rf_we1, rf_wa, rf_wd);
            end
         end
         push_expected(req_valid);
      end
   endtask

   task automatic test_back_to_back();
      rsp_t e;
      for (int s = 0; s < 6; s++) begin
         @(negedge clk);
         e = '0;
         if (sb.size() != 0) e = sb.pop_front();
         nchk++; if (rsp_valid !== e.vld) begin nerr++; $display("FAIL b2b rsp_valid %0d: got %b want %b", s, rsp_valid, e.vld); end
         nchk++; if (rsp_rd1 !== e.rd1) begin nerr++; $display("FAIL b2b rsp_rd1 %0d: got %h want %h", s, rsp_rd1, e.rd1); end
         nchk++; if (rsp_rd2 !== e.rd2) begin nerr++; $display("FAIL b2b rsp_rd2 %0d: got %h want %h", s, rsp_rd2, e.rd2); end
         req_lock  = '0;
         req_valid = (s < 5) ? 2'b01 : 2'b00;
         set_req(0, 1'b1, AW'(50+s), 32'h0000_5000 + s, AW'(49+s), AW'(50+s));
         #1;
         nchk++; if (req_ready !== req_valid) begin nerr++; $display("FAIL b2b ready %0d: got %b want %b", s, req_ready, req_valid); end
         push_expected(req_valid);
      end
   endtask

   task automatic test_mid_reset();
      rsp_t e;
      @(negedge clk);
      e = '0;
      if (sb.size() != 0) e = sb.pop_front();
      nchk++; if (rsp_valid !== e.vld) begin nerr++; $display("FAIL midrst prior rsp_valid: got %b want %b", rsp_valid, e.vld); end
      req_valid = 2'b01;
      req_lock  = '0;
      set_req(0, 1'b0, '0, '0, AW'(50), AW'(51));
      #1;
      nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL midrst grant: got %b want 01", req_ready); end
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      req_valid = 2'b11;
      sb.delete();
      @(negedge clk);
      nchk++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL midrst rsp_valid in reset: got %b want 00", rsp_valid); end
      nchk++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL midrst ready in reset: got %b want 00", req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      set_req(1, 1'b0, '0, '0, AW'(52), AW'(53));
      #1;
      nchk++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL midrst rsp_valid after release: got %b want 00", rsp_valid); end
      nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL midrst pointer: got %b want 01", req_ready); end
      push_expected(2'b01);
      @(negedge clk);
      e = sb.pop_front();
      nchk++; if (rsp_valid !== e.vld) begin nerr++; $display("FAIL midrst rsp_valid: got %b want %b", rsp_valid, e.vld); end
      nchk++; if (rsp_rd1 !== e.rd1) begin nerr++; $display("FAIL midrst rsp_rd1: got %h want %h", rsp_rd1, e.rd1); end
      req_valid = '0;
      @(negedge clk);
      nchk++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL midrst idle rsp_valid: got %b want 00", rsp_valid); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      mem_clr   = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      req_we    = '0;
      req_ra1   = '0;
      req_ra2   = '0;
      req_wa    = '0;
      req_wd    = '0;
      for (int k = 0; k < 2**AW; k++) shadow[k] = '0;
      repeat (2) @(negedge clk);
      mem_clr = 1'b0;
      test_reset();
      test_contention();
      test_lock();
      test_bypass();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/regfile_arb.md
REGFILE_ARB -- requirements
Module: regfile_arb

Interface
REQ-001 Parameters SHALL be: AW, 6, register address width; DW, 32, register data width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit 0 = core, bit 1 = debug.
REQ-005 req_ready  output  2  per-requester grant; a transfer occurs when valid and ready are both high.
REQ-006 req_lock  input  2  requester holds ownership after its current transfer.
REQ-007 req_we  input  2  per-requester write enable.
REQ-008 req_ra1, req_ra2, req_wa  input  2xAW each  per-requester read/write addresses.
REQ-009 req_wd  input  2xDW  per-requester write data.
REQ-010 rf_we1  output  1; rf_ra1, rf_ra2, rf_wa  output  AW; rf_wd  output  DW  drive the register file ports.
REQ-011 rf_rd1, rf_rd2  input  DW  register file read data, valid one cycle after the address is presented.
REQ-012 rsp_valid  output  2  one-hot response strobe per requester.
REQ-013 rsp_rd1, rsp_rd2  output  DW  response read data.

Function
REQ-014 The FSM SHALL have three states: IDLE, OWN0, OWN1.
REQ-015 IDLE: at most one req_ready bit SHALL be high per cycle; it is granted combinationally to the single valid requester, or by round-robin pointer when both are valid.
REQ-016 After a transfer by requester i with req_lock[i]=1, the FSM SHALL enter OWNi.
REQ-017 In OWNi, only requester i SHALL be granted; the other requester's ready SHALL stay 0.
REQ-018 The FSM SHALL leave OWNi for IDLE on the first cycle with req_lock[i]=0.
REQ-019 The round-robin pointer SHALL point to the non-winner after every IDLE-state transfer, and to the other requester on exit from OWNi.
REQ-020 The rf_* outputs SHALL mirror the granted requester's fields combinationally.
REQ-021 rf_we1 SHALL be high only when req_we of the transferring requester is high; it is 0 when there is no transfer.
REQ-022 rsp_valid[i] SHALL pulse exactly one cycle after a transfer by requester i, read or write.
REQ-023 rsp_rd1/rsp_rd2 SHALL equal rf_rd1/rf_rd2 in the rsp_valid cycle, and 0 otherwise.
REQ-024 Back-to-back transfers SHALL sustain one transfer per cycle with no bubble.
REQ-025 A requester dropping valid without a transfer SHALL neither advance the pointer nor change the state.

Reset
REQ-026 While rst_n=0: state=IDLE, pointer=0 (core first), req_ready=0, rsp_valid=0, rf_we1=0, rsp_rd1=rsp_rd2=0.
REQ-027 Asserting rst_n mid-transfer SHALL discard the pending response, with no rsp_valid after release.
REQ-028 The first grant SHALL be possible in the first posedge after rst_n deassertion.

Configuration
REQ-029 With RF_ARB_BYPASS_EN defined, a registered bypass SHALL apply: when a transfer writes wa with rf_we1 and reads ra1 (or ra2) equal to wa, the next-cycle rsp_rd1 (or rsp_rd2) SHALL return that cycle's wd.
REQ-030 Without RF_ARB_BYPASS_EN, the responses SHALL return the old register contents from rf_rd*, and no bypass logic shall exist.

Verification
REQ-031 Reset: hold rst_n=0 with both valid -> ready=00 and rsp_valid=00; release -> core granted first.
REQ-032 Contention: both valid, no lock, for 4 cycles -> grants alternate 01,10,01,10; each rsp_valid is 1 cycle later.
REQ-033 Lock: debug transfers with lock=1 for 3 cycles while core is valid -> core ready=0 throughout; core granted the cycle after lock drops.
REQ-034 Write/read same address: core writes wa=5, wd=0xDEADBEEF, ra1=5 -> bypass build gives rsp_rd1=0xDEADBEEF; non-bypass build gives the prior value 0.
REQ-035 Mid-operation reset: pulse rst_n low in the cycle after a grant -> no rsp_valid; state returns to IDLE with pointer=0.
